// File: rtl/rst_req_gen_pkg.sv
// rtl/rst_req_gen_pkg.sv - shared types and default timing for the reset request generator
package rst_req_pkg;

    // Request generator states; POR and PULSE are the only states driving a request
    typedef enum logic [1:0] {
        POR      = 2'd0,
        IDLE     = 2'd1,
        PULSE    = 2'd2,
        WAIT_REL = 2'd3
    } rrg_state_t;

    // Default timing: 2-flop synchronizer, 10 ms debounce and 16-clock request at 100 MHz
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_PULSE_CYCLES    = 16;

    // Larger of two integers, used to size the shared counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_req_gen_if.sv
// rtl/rst_req_gen_if.sv - button input and reset request outputs of the request generator
interface rst_req_gen_if;

    logic       btn_in;
    logic       rst_req_n;
    logic       busy;
    logic [7:0] req_count;

    // Board side: drives the raw button, observes the request
    modport master (
        output btn_in,
        input  rst_req_n,
        input  busy,
        input  req_count
    );

    // Generator side: samples the button, drives the request
    modport slave (
        input  btn_in,
        output rst_req_n,
        output busy,
        output req_count
    );

endinterface

// File: rtl/rst_req_gen_bit_sync.sv
// rtl/rst_req_gen_bit_sync.sv - parameterised N-flop single-bit synchronizer with async active-low clear
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the chain; clearing forces a known low level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_req_gen.sv
// rtl/rst_req_gen.sv - debounced pushbutton and power-on reset to fixed-width active-low reset request
module rst_req_gen
    import rst_req_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    rst_req_gen_if.slave bus
);

    // One counter serves debounce (press and release) and the request width
    localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, PULSE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    rrg_state_t    state;
    logic [CW-1:0] cnt;
    logic          btn_sync;
    logic          rst_req_n_q;
    logic          busy_q;
    logic [7:0]    req_count_q;

    // The raw button is asynchronous; only its synchronized copy reaches the FSM
    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (bus.btn_in),
        .q     (btn_sync)
    );

    // Request FSM with shared counter; outputs are registered alongside each state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= POR;
            cnt         <= '0;
            rst_req_n_q <= 1'b0;
            busy_q      <= 1'b1;
            req_count_q <= 8'd0;
        end else begin
            case (state)
                // Power-up request: hold low for PULSE_CYCLES, then demand a clean release
                // so a button held through power-up does not cause a second request
                POR: begin
                    if (cnt == P_LAST) begin
                        state       <= WAIT_REL;
                        cnt         <= '0;
                        rst_req_n_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Qualify a press: any synced low restarts the debounce count
                IDLE: begin
                    if (!btn_sync) begin
                        cnt <= '0;
                    end else if (cnt == D_LAST) begin
                        state       <= PULSE;
                        cnt         <= '0;
                        rst_req_n_q <= 1'b0;
                        busy_q      <= 1'b1;
                        req_count_q <= req_count_q + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Fixed-width request; the button is not looked at here
                PULSE: begin
                    if (cnt == P_LAST) begin
                        state       <= WAIT_REL;
                        cnt         <= '0;
                        rst_req_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Qualify the release: any synced high restarts the count, so a held or
                // re-bounced button can never start another request from here
                WAIT_REL: begin
                    if (btn_sync) begin
                        cnt <= '0;
                    end else if (cnt == D_LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state       <= POR;
                    cnt         <= '0;
                    rst_req_n_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rst_req_n = rst_req_n_q;
    assign bus.busy      = busy_q;
    assign bus.req_count = req_count_q;

endmodule
